// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - default sizing constants and count-width helper for sync_fifo
package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_DEPTH    = 16;
  localparam int DEFAULT_AE_LEVEL = 2;

  // Occupancy must represent 0..depth inclusive, hence one bit above the pointer width.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - WIDTH x DEPTH storage, one write port, one registered read port
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage is deliberately not reset; stale words are never addressable after a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered status flags
// Define SYNC_FIFO_ERR_EN to enable the sticky overflow/underflow flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = DEFAULT_AE_LEVEL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          write,
  input  logic                          read,
  output logic [WIDTH-1:0]              data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, af_q, ae_q;
  logic          wr_en, rd_en;

  // Acceptance uses the registered flags, i.e. the state before this edge.
  assign wr_en = write && !full_q;
  assign rd_en = read && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= CW'(AF_LEVEL));
      ae_q     <= (count_d <= CW'(AE_LEVEL));
    end
  end

  sync_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_q),
    .wr_data(data_in),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr_q),
    .rd_data(data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (write && full_q) ovf_q <= 1'b1;
      if (read && empty_q) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >=4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (1..DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port data_in  input  WIDTH  write data.
REQ-008 SHALL have port write  input  1  write request.
REQ-009 SHALL have port read  input  1  read request.
REQ-010 SHALL have port data_out  output  WIDTH  registered read data.
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port empty  output  1  count==0.
REQ-013 SHALL have port almost_full  output  1  count>=AF_LEVEL.
REQ-014 SHALL have port almost_empty  output  1  count<=AE_LEVEL.
REQ-015 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-016 SHALL have ports overflow and underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL accept a write when write && !full, storing data_in at wr_ptr and advancing wr_ptr.
REQ-018 SHALL accept a read when read && !empty, loading data_out from rd_ptr on that edge (1-cycle latency) and advancing rd_ptr.
REQ-019 SHALL hold data_out unchanged on cycles without an accepted read.
REQ-020 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-021 SHALL judge acceptance on pre-edge flags: full with both requests -> read only; empty with both -> write only.
REQ-022 SHALL, on simultaneous accepted read and write, keep count unchanged and the read SHALL return the old entry, never the word being written.
REQ-023 SHALL update count +1 on write only, -1 on read only, 0 otherwise; never beyond 0..DEPTH.
REQ-024 SHALL register full, empty, almost_full and almost_empty so they reflect the count after the same edge.
REQ-025 SHALL ignore a rejected write or read with no change to pointers, count, memory or data_out.

Reset
REQ-026 SHALL on rst, immediately and regardless of clk, clear pointers, count, data_out, overflow and underflow to 0; set empty=1, almost_empty=1, full=0, almost_full=0.
REQ-027 SHALL discard all stored words on reset mid-operation; memory contents are not reset and are unreadable until rewritten.

Configuration
REQ-028 SHALL with SYNC_FIFO_ERR_EN defined set overflow on any write while full and underflow on any read while empty, both held until reset.
REQ-029 SHALL without SYNC_FIFO_ERR_EN keep overflow and underflow ports present and tied to 0.

Structure
REQ-030 SHALL place the default parameter constants and a count-width helper function in package sync_fifo_pkg.
REQ-031 SHALL implement storage in sub-module sync_fifo_mem: one write port, one registered read port, WIDTH x DEPTH.

Verification
REQ-032 SHALL check fill: DEPTH=16, write 16 words 0x01..0x10 -> full=1 and count=16 after 16th edge; almost_full=1 from count 14.
REQ-033 SHALL check drain: read 16 times -> data_out 0x01..0x10 in order, one cycle after each read; empty=1 and almost_empty=1 from count 2.
REQ-034 SHALL check wrap and concurrency: hold count=8, assert read and write together for 40 cycles -> count stays 8, data order preserved across pointer wrap.
REQ-035 SHALL check boundary: full with read+write asserted -> read only, count 15; empty with both -> write only, count 1, data_out unchanged.
REQ-036 SHALL check errors with SYNC_FIFO_ERR_EN: write while full -> overflow=1 and held; read while empty -> underflow=1; without macro both stay 0.
REQ-037 SHALL check async reset: rst asserted mid-cycle at count=5 -> count=0, empty=1, data_out=0 before next clk edge.
